// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencer for a binary up-counter with a prescaled tick,
// one-shot/periodic modes, pause/resume and a registered terminal-count strobe.
module counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [PW-1:0]    cfg_presc,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [PW-1:0]    prescCnt_q, prescCnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;

  logic tick;
  logic atLimit;
  logic cfgOpen;

  assign tick    = (state_q == RUN) && (prescCnt_q == presc_q);
  assign atLimit = (count_q == limit_q);
  assign cfgOpen = (state_q == IDLE) || (state_q == DONE);

  // Next-state logic; a terminal tick is always processed even when stop
  // arrives on the same cycle, and reaching DONE overrides the pause.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    prescCnt_d = prescCnt_q;
    limit_d    = limit_q;
    presc_d    = presc_q;
    mode_d     = mode_q;

    if (cfg_we && cfgOpen) begin
      limit_d = cfg_limit;
      presc_d = cfg_presc;
      mode_d  = cfg_mode;
    end
    err_d = cfg_we && !cfgOpen;
    tc_d  = tick && atLimit;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          count_d    = '0;
          prescCnt_d = '0;
        end
      end
      RUN: begin
        if (tick) begin
          prescCnt_d = '0;
          if (!atLimit) begin
            count_d = count_q + 1'b1;
          end else if (mode_q) begin
            count_d = '0;
          end else begin
            state_d = DONE;
          end
        end else begin
          prescCnt_d = prescCnt_q + 1'b1;
        end
        if (stop && (state_d != DONE)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (start && !stop) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == HOLD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      prescCnt_q <= '0;
      limit_q    <= '1;
      presc_q    <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tc_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      prescCnt_q <= prescCnt_d;
      limit_q    <= limit_d;
      presc_q    <= presc_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tc_q       <= tc_d;
      err_q      <= err_d;
    end
  end

  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tc_pulse = tc_q;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus a random run, checked against
// a model that derives the count from the number of cycles spent running.
module tb_counter_ctrl;

  localparam int WIDTH = 4;
  localparam int PW    = 4;

  logic             clk;
  logic             rst;
  logic             cfgWe;
  logic [WIDTH-1:0] cfgLimit;
  logic [PW-1:0]    cfgPresc;
  logic             cfgMode;
  logic             startIn;
  logic             stopIn;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tcPulse;
  logic             done;
  logic             cfgErr;
  logic [WIDTH+3:0] obsVec;

  int checks = 0;
  int fails  = 0;

  counter_ctrl #(.WIDTH(WIDTH), .PW(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfgWe),
    .cfg_limit(cfgLimit),
    .cfg_presc(cfgPresc),
    .cfg_mode (cfgMode),
    .start    (startIn),
    .stop     (stopIn),
    .count    (count),
    .busy     (busy),
    .tc_pulse (tcPulse),
    .done     (done),
    .cfg_err  (cfgErr)
  );

  assign obsVec = {count, busy, done, tcPulse, cfgErr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The model only tracks how many cycles the counter has spent running;
  // count and terminal events follow from division by the tick length.
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mphase_e;
  mphase_e mPhase;
  int      mLimit, mPresc, mMode, runCycles, expCount;
  bit      expTc, expErr;

  task automatic modelReset();
    mPhase    = M_IDLE;
    mLimit    = (1 << WIDTH) - 1;
    mPresc    = 0;
    mMode     = 0;
    runCycles = 0;
    expCount  = 0;
    expTc     = 0;
    expErr    = 0;
  endtask

  task automatic modelStep();
    int tickLen;
    expTc  = 0;
    expErr = 0;
    case (mPhase)
      M_IDLE, M_DONE: begin
        if (cfgWe) begin
          mLimit = cfgLimit;
          mPresc = cfgPresc;
          mMode  = cfgMode;
        end
        if (startIn) begin
          mPhase    = M_RUN;
          runCycles = 0;
          expCount  = 0;
        end
      end
      M_RUN: begin
        expErr  = cfgWe;
        runCycles++;
        tickLen = mPresc + 1;
        if (runCycles % (tickLen * (mLimit + 1)) == 0) expTc = 1;
        if (mMode == 0 && runCycles == tickLen * (mLimit + 1)) begin
          mPhase   = M_DONE;
          expCount = mLimit;
        end else begin
          expCount = (runCycles / tickLen) % (mLimit + 1);
          if (stopIn) mPhase = M_HOLD;
        end
      end
      M_HOLD: begin
        expErr = cfgWe;
        if (startIn && !stopIn) mPhase = M_RUN;
      end
    endcase
  endtask

  function automatic logic [WIDTH+3:0] expVec();
    logic [WIDTH-1:0] c;
    c = expCount[WIDTH-1:0];
    return {c, (mPhase == M_RUN) || (mPhase == M_HOLD), mPhase == M_DONE, expTc, expErr};
  endfunction

  task automatic applyStimulus(input logic we, input int lim, input int pr,
                               input logic md, input logic st, input logic sp);
    cfgWe    = we;
    cfgLimit = lim[WIDTH-1:0];
    cfgPresc = pr[PW-1:0];
    cfgMode  = md;
    startIn  = st;
    stopIn   = sp;
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    modelReset();
    repeat (2) @(negedge clk);
    checks++;
    if (obsVec !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs got %b want %b", obsVec, {(WIDTH+4){1'b0}});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_oneshot();
    logic [WIDTH-1:0] wantCnt;
    doReset();
    applyStimulus(1, 5, 0, 0, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checks++;
    if ({count, busy, done} !== {4'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL oneshot_start got cnt=%0d busy=%b done=%b want 0 1 0", count, busy, done);
    end
    for (int i = 1; i <= 8; i++) begin
      cycle();
      wantCnt = (i < 6) ? i[WIDTH-1:0] : 4'd5;
      checks++;
      if ({count, done, tcPulse} !== {wantCnt, i >= 6, i == 6}) begin
        fails++;
        $display("[TB] FAIL oneshot_seq cyc=%0d got cnt=%0d done=%b tc=%b want %0d %b %b",
                 i, count, done, tcPulse, wantCnt, i >= 6, i == 6);
      end
      checks++;
      if (obsVec !== expVec()) begin
        fails++;
        $display("[TB] FAIL oneshot_model cyc=%0d got %b want %b", i, obsVec, expVec());
      end
    end
  endtask

  task automatic test_periodic();
    logic [WIDTH-1:0] wantCnt;
    doReset();
    applyStimulus(1, 3, 2, 1, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      cycle();
      wantCnt = 4'((i / 3) % 4);
      checks++;
      if ({count, busy, tcPulse} !== {wantCnt, 1'b1, (i % 12) == 0}) begin
        fails++;
        $display("[TB] FAIL periodic_seq cyc=%0d got cnt=%0d busy=%b tc=%b want %0d 1 %b",
                 i, count, busy, tcPulse, wantCnt, (i % 12) == 0);
      end
      checks++;
      if (obsVec !== expVec()) begin
        fails++;
        $display("[TB] FAIL periodic_model cyc=%0d got %b want %b", i, obsVec, expVec());
      end
    end
  endtask

  task automatic test_pause_resume();
    logic [WIDTH-1:0] wantCnt;
    doReset();
    applyStimulus(1, 9, 0, 0, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    applyStimulus(0, 0, 0, 0, 0, 1);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if ({count, busy, done} !== {4'd4, 1'b1, 1'b0} || obsVec !== expVec()) begin
        fails++;
        $display("[TB] FAIL hold_frozen cyc=%0d got cnt=%0d busy=%b done=%b want 4 1 0",
                 i, count, busy, done);
      end
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int j = 1; j <= 7; j++) begin
      cycle();
      wantCnt = (j < 6) ? 4'(4 + j) : 4'd9;
      checks++;
      if ({count, done, tcPulse} !== {wantCnt, j >= 6, j == 6} || obsVec !== expVec()) begin
        fails++;
        $display("[TB] FAIL resume_seq cyc=%0d got cnt=%0d done=%b tc=%b want %0d %b %b",
                 j, count, done, tcPulse, wantCnt, j >= 6, j == 6);
      end
    end
  endtask

  task automatic test_cfg_reject();
    doReset();
    applyStimulus(1, 6, 0, 0, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycle();
    applyStimulus(1, 2, 0, 0, 0, 0);
    for (int i = 2; i <= 8; i++) begin
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checks++;
      if ({cfgErr, done, count} !== {i == 2, i >= 7, (i < 7) ? 4'(i) : 4'd6}
          || obsVec !== expVec()) begin
        fails++;
        $display("[TB] FAIL cfg_reject cyc=%0d got err=%b done=%b cnt=%0d want %b %b %0d",
                 i, cfgErr, done, count, i == 2, i >= 7, (i < 7) ? i : 6);
      end
    end
    applyStimulus(1, 3, 0, 0, 0, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checks++;
    if ({cfgErr, done} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL cfg_accept_done got err=%b done=%b want 0 1", cfgErr, done);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (4) cycle();
    checks++;
    if ({count, done, tcPulse} !== {4'd3, 1'b1, 1'b1} || obsVec !== expVec()) begin
      fails++;
      $display("[TB] FAIL cfg_new_limit got cnt=%0d done=%b tc=%b want 3 1 1", count, done, tcPulse);
    end
  endtask

  task automatic test_limit_zero();
    doReset();
    applyStimulus(1, 0, 0, 1, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle();
      checks++;
      if ({count, tcPulse, busy} !== {4'd0, 1'b1, 1'b1} || obsVec !== expVec()) begin
        fails++;
        $display("[TB] FAIL limit_zero cyc=%0d got cnt=%0d tc=%b busy=%b want 0 1 1",
                 i, count, tcPulse, busy);
      end
    end
    applyStimulus(0, 0, 0, 0, 1, 1);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    checks++;
    if ({count, tcPulse, busy, done} !== {4'd0, 1'b0, 1'b1, 1'b0} || obsVec !== expVec()) begin
      fails++;
      $display("[TB] FAIL start_stop_hold got cnt=%0d tc=%b busy=%b done=%b want 0 0 1 0",
               count, tcPulse, busy, done);
    end
  endtask

  task automatic test_reset_midrun();
    doReset();
    applyStimulus(1, 9, 0, 0, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    checks++;
    if (count !== 4'd3) begin
      fails++;
      $display("[TB] FAIL midrun_precount got %0d want 3", count);
    end
    rst = 1'b1;
    #1;
    modelReset();
    checks++;
    if ({count, busy, tcPulse, done} !== '0) begin
      fails++;
      $display("[TB] FAIL async_reset got cnt=%0d busy=%b tc=%b done=%b want 0 0 0 0",
               count, busy, tcPulse, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      cycle();
      checks++;
      if ({count, done, tcPulse} !== {(i < 16) ? 4'(i) : 4'd15, i >= 16, i == 16}
          || obsVec !== expVec()) begin
        fails++;
        $display("[TB] FAIL default_limit cyc=%0d got cnt=%0d done=%b tc=%b", i, count, done, tcPulse);
      end
    end
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 15), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 7) == 0);
      cycle();
      checks++;
      if (obsVec !== expVec()) begin
        fails++;
        $display("[TB] FAIL random cyc=%0d got %b want %b", i, obsVec, expVec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause_resume();
    test_cfg_reject();
    test_limit_zero();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
